umi_outstanding_limiter: RTL
============================

# umi_outstanding_limiter

Request-flow regulator placed directly upstream of `umi_mem_agent`, between the host-side UMI request/response channels and the device `udev_req_*`/`udev_resp_*` ports. It caps the number of in-flight response-generating transactions at `MAXOUT` by stalling the request channel. It tracks completions on the response channel and provides quiesce/idle control plus a sticky protocol-error flag.

## Interface
- `CW`, 32, UMI command width
- `AW`, 64, UMI address width
- `DW`, 128, UMI data width
- `MAXOUT`, 4, max outstanding response-generating transactions (1..255)
- `CNTW`, `$clog2(MAXOUT+1)`, outstanding-counter width
- `clk`  in  1  sole clock; all logic on rising edge
- `nreset`  in  1  synchronous, active-low reset
- `uhost_req_valid`/`uhost_req_ready`  in/out  1  host request handshake
- `uhost_req_cmd`/`_dstaddr`/`_srcaddr`/`_data`  in  CW/AW/AW/DW  host request payload
- `udev_req_valid`/`udev_req_ready`  out/in  1  request handshake toward mem agent
- `udev_req_cmd`/`_dstaddr`/`_srcaddr`/`_data`  out  CW/AW/AW/DW  forwarded payload
- `udev_resp_valid`/`udev_resp_ready`  in/out  1  response handshake from mem agent
- `udev_resp_cmd`/`_dstaddr`/`_srcaddr`/`_data`  in  CW/AW/AW/DW  response payload
- `uhost_resp_valid`/`uhost_resp_ready`  out/in  1  response handshake to host
- `uhost_resp_cmd`/`_dstaddr`/`_srcaddr`/`_data`  out  CW/AW/AW/DW  forwarded response
- `quiesce`  in  1  block all new requests while high
- `idle`  out  1  outstanding count == 0
- `outstanding`  out  CNTW  current in-flight count
- `proto_err`  out  1  sticky: response EOM seen with count == 0
- `stall_cycles`  out  32  saturating stall counter (see Configuration)

## Operation
- Opcode = `cmd[4:0]`; EOM = `cmd[22]`. Response-generating requests: READ (0x01), WRITE (0x03), ATOMIC (0x09). All other request opcodes (including POSTED 0x05) are not counted.
- Payload buses pass through combinationally in both directions. No data is stored.
- `gate` = `quiesce` OR (request is response-generating AND EOM AND `outstanding` == MAXOUT).
- `udev_req_valid` = `uhost_req_valid` & !`gate`; `uhost_req_ready` = `udev_req_ready` & !`gate`.
- Only the EOM beat of a counted transaction is gated. Earlier beats of a multi-beat request always pass.
- Response path is a pure wire: `uhost_resp_valid` = `udev_resp_valid`; `udev_resp_ready` = `uhost_resp_ready`.
- `inc` = request handshake on a counted opcode with EOM=1. `dec` = response handshake with EOM=1.
- Counter update:
  - `inc` & !`dec`: +1
  - `dec` & !`inc`: −1
  - both or neither: hold
- Underflow: `dec` with `outstanding` == 0 holds the count at 0 and sets `proto_err`. `proto_err` clears only on reset.
- Overflow cannot occur, because gating blocks `inc` at MAXOUT. Simultaneous `inc` and `dec` at MAXOUT is impossible for the same reason.
- `idle` = (`outstanding` == 0), combinational from the register.

## Timing
- Zero-cycle latency on all datapaths. Gating decisions use the registered count only, so there is no combinational path from the response handshake to `uhost_req_ready`.
- A slot freed by `dec` in cycle N is usable by a request in cycle N+1.
- `quiesce` asserted in cycle N blocks the handshake in cycle N. Requests already issued still complete, and their responses still decrement the count.
- Reset (`nreset` low at a rising edge) sets:
  - `outstanding` = 0, `idle` = 1, `proto_err` = 0, `stall_cycles` = 0
  - `uhost_req_ready`/`udev_req_valid` follow the combinational equations with count 0
- Reset mid-operation discards in-flight tracking. Late responses after reset set `proto_err`.

## Configuration
- Macro `UMI_OUTSTANDING_LIMITER_STATS_EN`.
- Defined: `stall_cycles` increments each cycle where `uhost_req_valid` & `gate` & !`quiesce`, and saturates at 0xFFFFFFFF.
- Undefined: the counter is not built and `stall_cycles` is tied to 0.

## Test plan
- MAXOUT=4: issue 6 back-to-back READs with EOM=1 and hold responses off. Expect 4 accepted, `outstanding`=4, `uhost_req_ready`=0. Release one response: the 5th is accepted the next cycle.
- 10 POSTED writes with the response path idle: all accepted at 1/cycle, `outstanding` stays 0, `idle`=1.
- At `outstanding`=2, a READ EOM handshake and a response EOM handshake in the same cycle: `outstanding` stays 2.
- 3-beat WRITE (EOM only on beat 3) at `outstanding`=MAXOUT: beats 1–2 pass, beat 3 stalls until a response EOM.
- Response EOM with `outstanding`=0: `proto_err`=1 next cycle and stays set, count stays 0. Then pulse `nreset`: `proto_err`=0.
- With `quiesce`=1, READ pending for 5 cycles: no handshake. With the stats macro defined, `stall_cycles` stays 0. In a full-count stall of 7 cycles, `stall_cycles`=7.

Source files
------------

// File: rtl/umi_outstanding_limiter_if.sv
// UMI valid/ready channel: command, addresses and data travelling with a handshake.
// master drives the payload and valid; slave returns ready.
interface umi_outstanding_limiter_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 128
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;

    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_outstanding_limiter.sv
// Caps in-flight response-generating UMI transactions at MAXOUT by stalling the request channel.
// Optional stall statistics counter: define UMI_OUTSTANDING_LIMITER_STATS_EN.
module umi_outstanding_limiter #(
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 128,
    parameter int MAXOUT = 4,
    parameter int CNTW   = $clog2(MAXOUT + 1)
) (
    input  logic                      clk,
    input  logic                      nreset,
    umi_outstanding_limiter_if.slave  uhost_req,
    umi_outstanding_limiter_if.master udev_req,
    umi_outstanding_limiter_if.slave  udev_resp,
    umi_outstanding_limiter_if.master uhost_resp,
    input  logic                      quiesce,
    output logic                      idle,
    output logic [CNTW-1:0]           outstanding,
    output logic                      proto_err,
    output logic [31:0]               stall_cycles
);

    if (MAXOUT < 1 || MAXOUT > 255 || CW < 23 || AW < 1 || DW < 1) begin : g_bad_params
        $error("umi_outstanding_limiter: unsupported parameter set");
    end

    localparam logic [CNTW-1:0] MAXCNT = CNTW'(MAXOUT);

    logic [CNTW-1:0] count_q, count_d;
    logic            proto_err_q, proto_err_d;
    logic [4:0]      req_opcode;
    logic            req_counted_eom;
    logic            gate;
    logic            inc, dec;

    assign req_opcode      = uhost_req.cmd[4:0];
    assign req_counted_eom = uhost_req.cmd[22] &&
                             (req_opcode == 5'h01 || req_opcode == 5'h03 || req_opcode == 5'h09);

    // Only the registered count feeds the gate, keeping response ready out of the request path.
    assign gate = quiesce | (req_counted_eom & (count_q == MAXCNT));

    assign udev_req.valid   = uhost_req.valid & ~gate;
    assign uhost_req.ready  = udev_req.ready & ~gate;
    assign udev_req.cmd     = uhost_req.cmd;
    assign udev_req.dstaddr = uhost_req.dstaddr;
    assign udev_req.srcaddr = uhost_req.srcaddr;
    assign udev_req.data    = uhost_req.data;

    assign uhost_resp.valid   = udev_resp.valid;
    assign udev_resp.ready    = uhost_resp.ready;
    assign uhost_resp.cmd     = udev_resp.cmd;
    assign uhost_resp.dstaddr = udev_resp.dstaddr;
    assign uhost_resp.srcaddr = udev_resp.srcaddr;
    assign uhost_resp.data    = udev_resp.data;

    assign inc = uhost_req.valid & uhost_req.ready & req_counted_eom;
    assign dec = udev_resp.valid & udev_resp.ready & udev_resp.cmd[22];

    always_comb begin
        count_d     = count_q;
        proto_err_d = proto_err_q;
        if (dec && count_q == '0) begin
            proto_err_d = 1'b1;
        end
        if (inc && !dec) begin
            count_d = count_q + CNTW'(1);
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign outstanding = count_q;
    assign idle        = (count_q == '0);
    assign proto_err   = proto_err_q;

`ifdef UMI_OUTSTANDING_LIMITER_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Quiesce stalls are deliberate, so only capacity stalls are counted.
    always_comb begin
        stall_d = stall_q;
        if (uhost_req.valid && gate && !quiesce && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
